// File: rtl/coproc_result_tx_if.sv
// rtl/coproc_result_tx_if.sv - result handshake and MCU beat link bundle
interface coproc_result_tx_if #(
  parameter int DATA_W = 8,
  parameter int LANE_W = 4
);
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;
  logic              ack_tag;
  logic [LANE_W-1:0] lane;
  logic              tx_tag;
  logic              busy;
  logic              proto_err;

  // Producer / MCU side
  modport master (
    output res_valid, res_data, ack_tag,
    input  res_ready, lane, tx_tag, busy, proto_err
  );

  // Transmitter side
  modport slave (
    input  res_valid, res_data, ack_tag,
    output res_ready, lane, tx_tag, busy, proto_err
  );
endinterface

// File: rtl/coproc_result_tx.sv
// rtl/coproc_result_tx.sv - serializes coprocessor results to the MCU as toggle-tagged beats
module coproc_result_tx #(
  parameter int DATA_W = 8,
  parameter int LANE_W = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  coproc_result_tx_if.slave  bus
);
  localparam int BEATS = DATA_W / LANE_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t            state, state_nx;
  logic              ack_s1, ack_s2;
  logic [DATA_W-1:0] sr, sr_nx, sr_shift;
  logic [LANE_W-1:0] lane_q, lane_nx;
  logic              tag_q, tag_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              err_q, err_now;
  logic              last_beat;

  assign sr_shift  = sr >> LANE_W;
  assign last_beat = (cnt == CNT_W'(BEATS - 1));
  // Idle invariant: the MCU's tag must echo ours whenever no beat is outstanding.
  assign err_now   = (state == IDLE) && (ack_s2 != tag_q);

  assign bus.res_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.lane      = lane_q;
  assign bus.tx_tag    = tag_q;
  // Flag is visible as soon as the synchronized mismatch appears, then held sticky.
  assign bus.proto_err = err_q | err_now;

  // Two-flop synchronizer for the MCU's asynchronous acknowledge tag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= bus.ack_tag;
      ack_s2 <= ack_s1;
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next state and datapath: accept a word, then advance one beat per matching ack.
  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    lane_nx  = lane_q;
    tag_nx   = tag_q;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (bus.res_valid) begin
          sr_nx    = bus.res_data;
          lane_nx  = bus.res_data[LANE_W-1:0];
          tag_nx   = ~tag_q;
          cnt_nx   = '0;
          state_nx = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ack_s2 == tag_q) begin
          if (last_beat) begin
            state_nx = IDLE;
          end else begin
            sr_nx   = sr_shift;
            lane_nx = sr_shift[LANE_W-1:0];
            tag_nx  = ~tag_q;
            cnt_nx  = cnt + CNT_W'(1);
          end
        end
      end
    endcase
  end

  // Datapath registers and sticky protocol error.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr     <= '0;
      lane_q <= '0;
      tag_q  <= 1'b0;
      cnt    <= '0;
      err_q  <= 1'b0;
    end else begin
      sr     <= sr_nx;
      lane_q <= lane_nx;
      tag_q  <= tag_nx;
      cnt    <= cnt_nx;
      if (err_now) err_q <= 1'b1;
    end
  end
endmodule
